// File: rtl/saa_wb_arbiter.sv
// saa_wb_arbiter: write-back arbiter from the systolic-array partition to the
// single activation SRAM write port. Each SA owns a small {addr, data} FIFO; a
// round-robin arbiter drains the FIFOs into one registered valid/ready stage.
// Optional build macro: SAA_WB_STATS_EN adds a 16-bit accepted-write counter
// output (wr_count). Without it the port and counter are absent.
module saa_wb_arbiter #(
  parameter int unsigned SA_NUM     = 3,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [SA_NUM-1:0]        wb_valid,
  input  logic [SA_NUM*ADDR_W-1:0] wb_addr,
  input  logic [SA_NUM*DATA_W-1:0] wb_data,
  input  logic                     flush,
  output logic                     sram_wr_en,
  output logic [ADDR_W-1:0]        sram_wr_addr,
  output logic [DATA_W-1:0]        sram_wr_data,
  input  logic                     sram_wr_ready,
  output logic [SA_NUM-1:0]        fifo_full,
  output logic [SA_NUM-1:0]        overflow_err,
  output logic                     busy
`ifdef SAA_WB_STATS_EN
  ,
  output logic [15:0]              wr_count
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned GntW = (SA_NUM > 1) ? $clog2(SA_NUM) : 1;
  localparam int unsigned EntW = ADDR_W + DATA_W;

  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [GntW-1:0] LastSa   = GntW'(SA_NUM - 1);

  // FIFO storage and bookkeeping, one set per requester
  logic [EntW-1:0]             mem_q [SA_NUM][FIFO_DEPTH];
  logic [SA_NUM-1:0][PtrW-1:0] wr_ptr_q;
  logic [SA_NUM-1:0][PtrW-1:0] rd_ptr_q;
  logic [SA_NUM-1:0][CntW-1:0] count_q;
  logic [SA_NUM-1:0]           overflow_q;

  // Output stage and arbiter state
  logic              en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [GntW-1:0]   last_grant_q;

  logic [SA_NUM-1:0] not_empty;
  logic [SA_NUM-1:0] is_full;
  logic [SA_NUM-1:0] pop;
  logic [SA_NUM-1:0] push;
  logic [SA_NUM-1:0] drop;
  logic              stage_free;
  logic              grant_valid;
  logic [GntW-1:0]   grant_idx;
  logic [EntW-1:0]   grant_head;

  // Index 'off' positions after 'base', wrapping modulo SA_NUM (off <= SA_NUM)
  function automatic logic [GntW-1:0] rr_idx(input logic [GntW-1:0] base,
                                             input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= SA_NUM) sum = sum - SA_NUM;
    return GntW'(sum);
  endfunction

  // Per-FIFO status derived from registered counts only
  always_comb begin
    not_empty = '0;
    is_full   = '0;
    for (int unsigned i = 0; i < SA_NUM; i++) begin
      not_empty[i] = (count_q[i] != '0);
      is_full[i]   = (count_q[i] == DepthCnt);
    end
  end

  // Round-robin search: first non-empty FIFO strictly after last_grant
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant_q;
    for (int unsigned off = 1; off <= SA_NUM; off++) begin
      if (!grant_valid && not_empty[rr_idx(last_grant_q, off)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_idx(last_grant_q, off);
      end
    end
  end

  assign grant_head = mem_q[grant_idx][rd_ptr_q[grant_idx]];

  // Stage accepts a new word when empty or being consumed this cycle
  assign stage_free = !en_q || sram_wr_ready;

  // Pop/push/drop decisions; flush suppresses all of them
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    for (int unsigned i = 0; i < SA_NUM; i++) begin
      pop[i]  = !flush && stage_free && grant_valid && (grant_idx == GntW'(i));
      // A full FIFO still takes a push when its head leaves in the same cycle
      push[i] = !flush && wb_valid[i] && (!is_full[i] || pop[i]);
      drop[i] = !flush && wb_valid[i] && is_full[i] && !pop[i];
    end
  end

  // FIFO entry storage (no reset needed; validity is tracked by the counts)
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < SA_NUM; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {wb_addr[i*ADDR_W +: ADDR_W], wb_data[i*DATA_W +: DATA_W]};
      end
    end
  end

  // FIFO pointers, counts and sticky overflow flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= '0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= '0;
    end else begin
      for (int unsigned i = 0; i < SA_NUM; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count_q[i] <= count_q[i] + 1'b1;
          2'b01:   count_q[i] <= count_q[i] - 1'b1;
          default: count_q[i] <= count_q[i];
        endcase
      end
      overflow_q <= overflow_q | drop;
    end
  end

  // Registered SRAM write stage and round-robin pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      last_grant_q <= LastSa;
    end else if (flush) begin
      en_q         <= 1'b0;
      last_grant_q <= LastSa;
    end else if (stage_free) begin
      if (grant_valid) begin
        en_q         <= 1'b1;
        addr_q       <= grant_head[EntW-1 -: ADDR_W];
        data_q       <= grant_head[DATA_W-1:0];
        last_grant_q <= grant_idx;
      end else begin
        en_q <= 1'b0;
      end
    end
  end

`ifdef SAA_WB_STATS_EN
  logic [15:0] wr_count_q;

  // Count accepted SRAM writes, wrapping at 16 bits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_count_q <= '0;
    end else if (flush) begin
      wr_count_q <= '0;
    end else if (en_q && sram_wr_ready) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign wr_count = wr_count_q;
`endif

  assign sram_wr_en   = en_q;
  assign sram_wr_addr = addr_q;
  assign sram_wr_data = data_q;
  assign fifo_full    = is_full;
  assign overflow_err = overflow_q;
  assign busy         = (|not_empty) || en_q;

endmodule

// File: tb/tb_saa_wb_arbiter.sv
// Directed self-checking bench for saa_wb_arbiter (SA_NUM=3, ADDR_W=10, DATA_W=16, depth 4).
module tb_saa_wb_arbiter;

  localparam int SA_NUM = 3;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  logic                     clk = 1'b0;
  logic                     resetn = 1'b0;
  logic [SA_NUM-1:0]        wb_valid = '0;
  logic [SA_NUM*ADDR_W-1:0] wb_addr = '0;
  logic [SA_NUM*DATA_W-1:0] wb_data = '0;
  logic                     flush = 1'b0;
  logic                     sram_wr_en;
  logic [ADDR_W-1:0]        sram_wr_addr;
  logic [DATA_W-1:0]        sram_wr_data;
  logic                     sram_wr_ready = 1'b0;
  logic [SA_NUM-1:0]        fifo_full;
  logic [SA_NUM-1:0]        overflow_err;
  logic                     busy;
`ifdef SAA_WB_STATS_EN
  logic [15:0]              wr_count;
`endif

  int checks = 0;
  int failures = 0;

  saa_wb_arbiter #(
    .SA_NUM    (SA_NUM),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .flush        (flush),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .sram_wr_ready(sram_wr_ready),
    .fifo_full    (fifo_full),
    .overflow_err (overflow_err),
    .busy         (busy)
`ifdef SAA_WB_STATS_EN
    ,
    .wr_count     (wr_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1ns past the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input int sa, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_valid[sa] = 1'b1;
    wb_addr[sa*ADDR_W +: ADDR_W] = a;
    wb_data[sa*DATA_W +: DATA_W] = d;
  endtask

  function automatic logic [26:0] ow();
    return {sram_wr_en, sram_wr_addr, sram_wr_data};
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    checks++;
    if ({ow(), fifo_full, overflow_err, busy} !== 34'h0) begin
      failures++;
      $display("FAIL reset_outputs got %h want 0", {ow(), fifo_full, overflow_err, busy});
    end
`ifdef SAA_WB_STATS_EN
    checks++;
    if (wr_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_wr_count got %0d want 0", wr_count);
    end
`endif
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    sram_wr_ready = 1'b1;
    set_push(0, 10'h010, 16'h00ab);
    tick();
    wb_valid = '0;
    checks++;
    if (ow() !== 27'h0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_cycle1 got %h busy %b want 0 busy 1", ow(), busy);
    end
    tick();
    checks++;
    if (ow() !== {1'b1, 10'h010, 16'h00ab}) begin
      failures++;
      $display("FAIL single_write got %h want %h", ow(), {1'b1, 10'h010, 16'h00ab});
    end
    tick();
    checks++;
    if (sram_wr_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done got en %b busy %b want 0 0", sram_wr_en, busy);
    end
  endtask

  task automatic test_round_robin();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_push(0, 10'h100, 16'h00a0);
    set_push(1, 10'h200, 16'h00a1);
    set_push(2, 10'h300, 16'h00a2);
    tick();
    wb_valid = '0;
    tick();
    checks++;
    if (ow() !== {1'b1, 10'h100, 16'h00a0}) begin
      failures++;
      $display("FAIL rr_sa0 got %h want %h", ow(), {1'b1, 10'h100, 16'h00a0});
    end
    tick();
    checks++;
    if (ow() !== {1'b1, 10'h200, 16'h00a1}) begin
      failures++;
      $display("FAIL rr_sa1 got %h want %h", ow(), {1'b1, 10'h200, 16'h00a1});
    end
    tick();
    checks++;
    if (ow() !== {1'b1, 10'h300, 16'h00a2}) begin
      failures++;
      $display("FAIL rr_sa2 got %h want %h", ow(), {1'b1, 10'h300, 16'h00a2});
    end
    set_push(0, 10'h101, 16'h00b0);
    set_push(2, 10'h301, 16'h00b2);
    tick();
    wb_valid = '0;
    checks++;
    if (sram_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL rr_gap got en %b want 0", sram_wr_en);
    end
    tick();
    checks++;
    if (ow() !== {1'b1, 10'h101, 16'h00b0}) begin
      failures++;
      $display("FAIL rr_wrap_sa0 got %h want %h", ow(), {1'b1, 10'h101, 16'h00b0});
    end
    tick();
    checks++;
    if (ow() !== {1'b1, 10'h301, 16'h00b2}) begin
      failures++;
      $display("FAIL rr_wrap_sa2 got %h want %h", ow(), {1'b1, 10'h301, 16'h00b2});
    end
    tick();
    checks++;
    if (sram_wr_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rr_idle got en %b busy %b want 0 0", sram_wr_en, busy);
    end
  endtask

  task automatic test_backpressure();
    sram_wr_ready = 1'b0;
    set_push(0, 10'h040, 16'h1111);
    set_push(1, 10'h050, 16'h2222);
    tick();
    wb_valid = '0;
    tick();
    checks++;
    if (ow() !== {1'b1, 10'h040, 16'h1111}) begin
      failures++;
      $display("FAIL bp_first got %h want %h", ow(), {1'b1, 10'h040, 16'h1111});
    end
    set_push(0, 10'h041, 16'h1112);
    for (int c = 0; c < 5; c++) begin
      tick();
      wb_valid = '0;
      checks++;
      if (ow() !== {1'b1, 10'h040, 16'h1111} || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cycle %0d got %h busy %b want %h busy 1", c, ow(), busy,
                 {1'b1, 10'h040, 16'h1111});
      end
    end
    sram_wr_ready = 1'b1;
    tick();
    checks++;
    if (ow() !== {1'b1, 10'h050, 16'h2222}) begin
      failures++;
      $display("FAIL bp_drain_sa1 got %h want %h", ow(), {1'b1, 10'h050, 16'h2222});
    end
    tick();
    checks++;
    if (ow() !== {1'b1, 10'h041, 16'h1112}) begin
      failures++;
      $display("FAIL bp_drain_sa0 got %h want %h", ow(), {1'b1, 10'h041, 16'h1112});
    end
    tick();
    checks++;
    if (sram_wr_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle got en %b busy %b want 0 0", sram_wr_en, busy);
    end
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    sram_wr_ready = 1'b0;
    set_push(0, 10'h070, 16'h4444);
    tick();
    wb_valid = '0;
    tick();
    checks++;
    if (ow() !== {1'b1, 10'h070, 16'h4444}) begin
      failures++;
      $display("FAIL ovf_stage got %h want %h", ow(), {1'b1, 10'h070, 16'h4444});
    end
    for (int k = 0; k < 5; k++) begin
      a = 10'h060 + 10'(k);
      d = 16'h3000 + 16'(k);
      set_push(1, a, d);
      tick();
      wb_valid = '0;
      if (k == 2) begin
        checks++;
        if (fifo_full !== 3'b000) begin
          failures++;
          $display("FAIL ovf_not_full_3 got %b want 000", fifo_full);
        end
      end
      if (k == 3) begin
        checks++;
        if (fifo_full !== 3'b010 || overflow_err !== 3'b000) begin
          failures++;
          $display("FAIL ovf_full_4 got full %b err %b want 010 000", fifo_full, overflow_err);
        end
      end
      if (k == 4) begin
        checks++;
        if (fifo_full !== 3'b010 || overflow_err !== 3'b010) begin
          failures++;
          $display("FAIL ovf_drop_5 got full %b err %b want 010 010", fifo_full, overflow_err);
        end
      end
    end
    // Full FIFO popped and pushed in the same cycle
    sram_wr_ready = 1'b1;
    set_push(1, 10'h065, 16'h3005);
    tick();
    wb_valid = '0;
    checks++;
    if (ow() !== {1'b1, 10'h060, 16'h3000} || fifo_full !== 3'b010) begin
      failures++;
      $display("FAIL ovf_full_pop_push got %h full %b want %h full 010", ow(), fifo_full,
               {1'b1, 10'h060, 16'h3000});
    end
    for (int k = 1; k < 5; k++) begin
      a = (k == 4) ? 10'h065 : 10'h060 + 10'(k);
      d = (k == 4) ? 16'h3005 : 16'h3000 + 16'(k);
      tick();
      checks++;
      if (ow() !== {1'b1, a, d}) begin
        failures++;
        $display("FAIL ovf_drain %0d got %h want %h", k, ow(), {1'b1, a, d});
      end
    end
    tick();
    checks++;
    if (sram_wr_en !== 1'b0 || overflow_err !== 3'b010 || fifo_full !== 3'b000) begin
      failures++;
      $display("FAIL ovf_sticky got en %b err %b full %b want 0 010 000", sram_wr_en,
               overflow_err, fifo_full);
    end
  endtask

  task automatic test_flush();
    sram_wr_ready = 1'b0;
    set_push(0, 10'h080, 16'h6666);
    set_push(1, 10'h090, 16'h7777);
    tick();
    wb_valid = '0;
    tick();
    checks++;
    if (ow() !== {1'b1, 10'h080, 16'h6666}) begin
      failures++;
      $display("FAIL flush_pre got %h want %h", ow(), {1'b1, 10'h080, 16'h6666});
    end
    flush = 1'b1;
    set_push(2, 10'h0b0, 16'h9999);
    tick();
    flush = 1'b0;
    wb_valid = '0;
    checks++;
    if ({sram_wr_en, busy, overflow_err, fifo_full} !== 8'h00) begin
      failures++;
      $display("FAIL flush_clear got en %b busy %b err %b full %b want all 0", sram_wr_en, busy,
               overflow_err, fifo_full);
    end
    sram_wr_ready = 1'b1;
    set_push(2, 10'h0a0, 16'h5555);
    tick();
    wb_valid = '0;
    tick();
    checks++;
    if (ow() !== {1'b1, 10'h0a0, 16'h5555}) begin
      failures++;
      $display("FAIL flush_after got %h want %h", ow(), {1'b1, 10'h0a0, 16'h5555});
    end
    tick();
    checks++;
    if (sram_wr_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle got en %b busy %b want 0 0", sram_wr_en, busy);
    end
  endtask

  task automatic test_stats_and_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sram_wr_ready = 1'b1;
    for (int s = 0; s < 3; s++) set_push(s, 10'h200 + 10'(s), 16'hc000 + 16'(s));
    tick();
    for (int s = 0; s < 3; s++) set_push(s, 10'h210 + 10'(s), 16'hc010 + 16'(s));
    tick();
    wb_valid = '0;
    set_push(0, 10'h220, 16'hc020);
    tick();
    wb_valid = '0;
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (sram_wr_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stats_drained got en %b busy %b want 0 0", sram_wr_en, busy);
    end
`ifdef SAA_WB_STATS_EN
    checks++;
    if (wr_count !== 16'd7) begin
      failures++;
      $display("FAIL stats_wr_count got %0d want 7", wr_count);
    end
`endif
    // Asynchronous reset in the middle of a drain
    for (int s = 0; s < 3; s++) set_push(s, 10'h300 + 10'(s), 16'hd000 + 16'(s));
    tick();
    wb_valid = '0;
    tick();
    checks++;
    if (sram_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre got en %b want 1", sram_wr_en);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({ow(), fifo_full, overflow_err, busy} !== 34'h0) begin
      failures++;
      $display("FAIL areset_immediate got %h want 0", {ow(), fifo_full, overflow_err, busy});
    end
`ifdef SAA_WB_STATS_EN
    checks++;
    if (wr_count !== 16'd0) begin
      failures++;
      $display("FAIL areset_wr_count got %0d want 0", wr_count);
    end
`endif
    #2;
    resetn = 1'b1;
    tick();
    tick();
    checks++;
    if (sram_wr_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL areset_dropped got en %b busy %b want 0 0", sram_wr_en, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_flush();
    test_stats_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/saa_wb_arbiter.md
# saa_wb_arbiter

Write-back arbiter between the systolic-array partition and the single SRAM write port. It buffers each SA's pooled result and write address in a small per-SA FIFO and drains all FIFOs round-robin into one registered SRAM write channel with a valid/ready handshake. Inputs come from `saa_wb_pkt` plus the OR of each SA's `pool_rd_en`; the output drives the activation SRAM write port.

## Interface
Parameters:
- `SA_NUM`, 3, number of systolic arrays (requesters)
- `ADDR_W`, 10, SRAM address width
- `DATA_W`, 16, pooled output width
- `FIFO_DEPTH`, 4, entries per requester FIFO (power of 2, ≥2)

Ports:
- `clk`  in  1  clock, rising edge
- `resetn`  in  1  asynchronous active-low reset
- `wb_valid`  in  SA_NUM  per-SA write request (= |pool_rd_en[i])
- `wb_addr`  in  SA_NUM×ADDR_W  per-SA write address (fifo_wr_addr)
- `wb_data`  in  SA_NUM×DATA_W  per-SA write data (pool_out)
- `flush`  in  1  synchronous clear of all queued state
- `sram_wr_en`  out  1  write valid
- `sram_wr_addr`  out  ADDR_W  write address
- `sram_wr_data`  out  DATA_W  write data
- `sram_wr_ready`  in  1  SRAM accepts write this cycle
- `fifo_full`  out  SA_NUM  FIFO i holds FIFO_DEPTH entries
- `overflow_err`  out  SA_NUM  sticky: a request from SA i was dropped
- `busy`  out  1  any FIFO non-empty or sram_wr_en high

## Operation
- Per-SA FIFO stores {addr, data}. Push when `wb_valid[i]`.
  - Push is accepted if count < FIFO_DEPTH, or if the FIFO is full and popped in the same cycle.
  - Otherwise the entry is dropped, `overflow_err[i]` is set, and the count is unchanged.
- Output stage is a single register {sram_wr_en, addr, data}.
  - The stage is free when `sram_wr_en`=0, or when `sram_wr_en && sram_wr_ready` (consumed this cycle).
- Arbiter:
  - When the output stage is free, grant the first non-empty FIFO strictly after `last_grant`, searching circularly.
  - The granted FIFO pops; its head loads the output register; `last_grant` updates to the granted index.
  - With no non-empty FIFO, `sram_wr_en` goes to 0 on the next edge.
- Handshake: while `sram_wr_en`=1 and `sram_wr_ready`=0, `sram_wr_addr` and `sram_wr_data` hold stable and no pop occurs.
- `flush` (has priority over push, pop and grant):
  - empties all FIFOs and clears `sram_wr_en` and `overflow_err`
  - sets `last_grant` = SA_NUM-1, so SA0 is granted first
  - a `wb_valid` in the flush cycle is discarded
- Order is preserved per SA. No ordering guarantee across SAs beyond round-robin.
- Counters are $clog2(FIFO_DEPTH)+1 bits wide. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - `sram_wr_en`=0, `sram_wr_addr`=0, `sram_wr_data`=0
  - `fifo_full`=0, `overflow_err`=0, `busy`=0
  - all FIFO counts 0, `last_grant`=SA_NUM-1
- Reset mid-operation drops all queued and in-flight writes immediately (asynchronous).
- Latency: push at edge N (wb_valid sampled) → entry visible in cycle N+1 → `sram_wr_en`=1 in cycle N+2 if the output stage is free and the FIFO wins arbitration.
- Throughput: one write per cycle while `sram_wr_ready`=1 and any FIFO is non-empty.
- `fifo_full`, `busy` and `overflow_err` are registered or derived from registered counts; no combinational path from `wb_valid` to any output.
- `sram_wr_ready` → pop is combinational within the cycle. `sram_wr_ready` must not depend combinationally on `sram_wr_en`.

## Configuration
- `SAA_WB_STATS_EN` defined:
  - adds output `wr_count`, 16 bits, which increments on each `sram_wr_en && sram_wr_ready` and wraps 0xFFFF→0
  - `wr_count` is reset to 0 by `resetn` and by `flush`
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Single write: after reset, `sram_wr_ready`=1; pulse `wb_valid`=3'b001, addr 0x010, data 0x00AB → `sram_wr_en`=1 exactly 2 cycles later with 0x010/0x00AB, for one cycle; `busy` falls the next cycle.
- Round-robin: all three SAs push one entry in the same cycle (addr 0x100/0x200/0x300) → writes appear in consecutive cycles in order SA0, SA1, SA2; a subsequent simultaneous push from SA0 and SA2 grants SA0 first.
- Backpressure: hold `sram_wr_ready`=0 for 5 cycles with a write pending → addr/data stable; on release, each queued entry drains at one per cycle with no loss or duplication.
- Full/overflow: `sram_wr_ready`=0; SA1 pushes 5 entries → `fifo_full[1]`=1 after the 4th push, the 5th is dropped, and `overflow_err[1]`=1 (sticky). Full plus pop in the same cycle accepts the push.
- Flush: with FIFOs partly filled and `sram_wr_en`=1 held by `sram_wr_ready`=0, assert `flush` → next cycle `sram_wr_en`=0, `busy`=0, `overflow_err`=0; the next push from SA2 writes normally.
- Async reset and stats: assert `resetn`=0 mid-drain → all outputs 0 immediately. With `SAA_WB_STATS_EN`, 7 accepted writes give `wr_count`=7.
